// File: rtl/seq_capture.sv
// -----------------------------------------------------------------------------
// seq_capture
//
// This is the receive side of the 8-slot one-hot sequencer. On each clock it
// samples the per-slot data bus whenever a slot select is present. It checks
// that the slots arrive in order 0..7 and assembles them into one 8-slot frame.
// A completed frame is presented on `frame`, with a single-cycle `frame_valid`
// strobe. An out-of-order slot or a malformed select raises `sync_err`, adds one
// to a saturating error counter, and makes the block re-lock on its own.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sel[7:0]     in   one-hot slot select (all-zero = idle)
//   din[W-1:0]   in   slot data, sampled together with sel
//   frame        out  last completed frame; slot i at [i*W +: W]
//   frame_valid  out  one-cycle pulse when frame updates
//   locked       out  high while tracking an in-order sequence
//   slot_idx     out  index of the most recently accepted slot
//   sync_err     out  one-cycle pulse on a sequencing error
//   err_count    out  saturating count of sync_err pulses
// -----------------------------------------------------------------------------
module seq_capture #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     sel,
  input  logic [W-1:0]   din,
  output logic [8*W-1:0] frame,
  output logic           frame_valid,
  output logic           locked,
  output logic [2:0]     slot_idx,
  output logic           sync_err,
  output logic [7:0]     err_count
);

  typedef enum logic { HUNT, LOCK } state_t;
  typedef enum logic [1:0] { IN_IDLE, IN_VALID, IN_BAD } kind_t;

  state_t         state_q, state_d;
  logic   [2:0]   expected_q, expected_d;
  logic   [2:0]   slot_idx_d;
  logic   [W-1:0] slot_buf [8];

  kind_t          kind;
  logic   [2:0]   idx;
  logic           wr_en;
  logic           frame_load;
  logic           err;
  logic [8*W-1:0] frame_next;

  // Classify the select bus. A single set bit is the same as
  // (sel & (sel - 1)) == 0 for a nonzero value.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) idx = 3'(i);
    end
    if (sel == 8'd0)                        kind = IN_IDLE;
    else if ((sel & (sel - 8'd1)) == 8'd0)  kind = IN_VALID;
    else                                    kind = IN_BAD;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    expected_d = expected_q;
    slot_idx_d = slot_idx;
    wr_en      = 1'b0;
    frame_load = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      HUNT: begin
        // Everything except a clean slot 0 is dropped without raising an error.
        if (kind == IN_VALID && idx == 3'd0) begin
          wr_en      = 1'b1;
          slot_idx_d = 3'd0;
          expected_d = 3'd1;
          state_d    = LOCK;
        end
      end

      LOCK: begin
        unique case (kind)
          IN_IDLE: ; // Idle gaps of any length are legal, so all state is held.
          IN_VALID: begin
            if (idx == expected_q) begin
              wr_en      = 1'b1;
              slot_idx_d = idx;
              expected_d = expected_q + 3'd1;   // 7 wraps to 0 for back-to-back frames
              frame_load = (idx == 3'd7);
            end else begin
              err = 1'b1;
              if (idx == 3'd0) begin
                // An early slot 0 restarts the frame. The block stays locked,
                // so no HUNT cycle occurs.
                wr_en      = 1'b1;
                slot_idx_d = 3'd0;
                expected_d = 3'd1;
              end else begin
                state_d    = HUNT;
                expected_d = 3'd0;
              end
            end
          end
          default: begin // IN_BAD
            err        = 1'b1;
            state_d    = HUNT;
            expected_d = 3'd0;
          end
        endcase
      end

      default: state_d = HUNT;
    endcase
  end

  // The completed frame takes slot 7 straight from din, because that slot is
  // being written to the buffer on this same edge.
  always_comb begin
    frame_next = '0;
    for (int i = 0; i < 7; i++) begin
      frame_next[i*W +: W] = slot_buf[i];
    end
    frame_next[7*W +: W] = din;
  end

  // NOTE: the assembly buffer is deliberately not reset. Each slot is rewritten before any completion can publish it, so the buffer does not need reset wiring.
  always_ff @(posedge clk) begin
    if (wr_en) slot_buf[idx] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      expected_q  <= 3'd0;
      slot_idx    <= 3'd0;
      frame       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      slot_idx    <= slot_idx_d;
      frame_valid <= frame_load;
      sync_err    <= err;
      if (frame_load) frame <= frame_next;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign locked = (state_q == LOCK);

endmodule
